// File: rtl/temp_pkg.sv
// Shared types and helpers for the temperature monitor datapath.
package temp_pkg;

    // Raw sensor scale: 1/16 degC per LSB.
    localparam int LSB_PER_DEGC = 16;
    localparam int DEGC_SHIFT   = $clog2(LSB_PER_DEGC);

    // Read-cycle sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCUM,
        UPDATE
    } state_e;

    // Clamp a signed value into the signed 8-bit range [-128, 127].
    function automatic logic signed [7:0] sat8(input logic signed [31:0] v);
        if (v > 32'sd127) begin
            return 8'sh7f;
        end else if (v < -32'sd128) begin
            return 8'sh80;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/temp_fmt.sv
// Raw temperature to integer degC/degF conversion with registered outputs.
// The saturated degC value is also exposed combinationally so that a caller
// can act on it in the same cycle the registers load.
module temp_fmt
    import temp_pkg::*;
#(
    parameter int DATA_W = 13
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     load_i,
    input  logic signed [DATA_W-1:0] raw_i,
    output logic signed [7:0]        c_comb_o,
    output logic signed [7:0]        avg_c_o,
    output logic signed [7:0]        avg_f_o
);

    logic signed [7:0]  avg_c_q, avg_c_d;
    logic signed [7:0]  avg_f_q, avg_f_d;
    logic signed [31:0] f_wide;

    // Floor to whole degC, then degF = C*9/5 + 32 truncated toward zero.
    always_comb begin
        avg_c_d = sat8(32'(raw_i >>> DEGC_SHIFT));
        f_wide  = (32'(avg_c_d) * 32'sd9) / 32'sd5 + 32'sd32;
        avg_f_d = sat8(f_wide);
    end

    // Capture converted values only when the caller publishes a new average.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments keep every register sampling the
        // pre-edge values, so evaluation order between blocks cannot matter.
        if (reset_i) begin
            avg_c_q <= '0;
            avg_f_q <= '0;
        end else if (load_i) begin
            avg_c_q <= avg_c_d;
            avg_f_q <= avg_f_d;
        end
    end

    assign c_comb_o = avg_c_d;
    assign avg_c_o  = avg_c_q;
    assign avg_f_o  = avg_f_q;

endmodule

// File: rtl/temp_monitor.sv
// Paced sensor reader: requests a raw sample every SAMPLE_DIV cycles,
// averages 2^AVG_LOG2 samples and publishes degC/degF, min/max, hysteretic
// alarms and a sticky sensor-timeout fault.
module temp_monitor
    import temp_pkg::*;
#(
    parameter int DATA_W      = 13,
    parameter int AVG_LOG2    = 3,
    parameter int SAMPLE_DIV  = 25_000_000,
    parameter int TIMEOUT_CYC = 1_000_000,
    parameter int HYST        = 16
) (
    input  logic                     clk_100MHz,
    input  logic                     reset,
    output logic                     sample_req,
    input  logic                     raw_valid,
    input  logic signed [DATA_W-1:0] raw_data,
    input  logic signed [DATA_W-1:0] thr_high,
    input  logic signed [DATA_W-1:0] thr_low,
    input  logic                     clr_minmax,
    output logic                     avg_valid,
    output logic signed [DATA_W-1:0] avg_raw,
    output logic signed [7:0]        avg_c,
    output logic signed [7:0]        avg_f,
    output logic signed [7:0]        min_c,
    output logic signed [7:0]        max_c,
    output logic                     minmax_ok,
    output logic                     alarm_high,
    output logic                     alarm_low,
    output logic                     sensor_fault
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int WIN   = 1 << AVG_LOG2;
    localparam int PER_W = $clog2(SAMPLE_DIV + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int EXT_W = DATA_W + 2;

    state_e                    state_q, state_d;
    logic [PER_W-1:0]          period_q, period_d;
    logic [TO_W-1:0]           wait_q, wait_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      req_q, req_d;
    logic                      fault_q, fault_d;

    logic                      valid_q, valid_d;
    logic signed [DATA_W-1:0]  avg_raw_q, avg_raw_d;
    logic signed [7:0]         min_q, min_d;
    logic signed [7:0]         max_q, max_d;
    logic                      ok_q, ok_d;
    logic                      ah_q, ah_d;
    logic                      al_q, al_d;

    logic                      period_zero;
    logic                      upd;
    logic signed [DATA_W-1:0]  avg_now;
    logic signed [7:0]         c_now;
    logic signed [EXT_W-1:0]   avg_x, hi_set, hi_clr, lo_set, lo_clr;

    assign period_zero = (period_q == '0);
    assign upd         = (state_q == UPDATE);
    assign avg_now     = DATA_W'(acc_q >>> AVG_LOG2);

    assign avg_x  = EXT_W'(avg_now);
    assign hi_set = EXT_W'(thr_high);
    assign hi_clr = EXT_W'(thr_high) - EXT_W'(HYST);
    assign lo_set = EXT_W'(thr_low);
    assign lo_clr = EXT_W'(thr_low) + EXT_W'(HYST);

    // Sequencer next state plus pacing, timeout and accumulation datapath.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        wait_d   = wait_q;
        fault_d  = fault_q;
        req_d    = 1'b0;
        period_d = period_zero ? PER_W'(SAMPLE_DIV - 1) : period_q - 1'b1;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (period_zero) begin
                    req_d   = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (raw_valid) begin
                    acc_d   = acc_q + ACC_W'(raw_data);
                    cnt_d   = cnt_q + 1'b1;
                    fault_d = 1'b0;
                    state_d = ACCUM;
                end else if (wait_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    // Sensor went silent: drop the partial window.
                    fault_d = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            ACCUM: begin
                state_d = (cnt_q == CNT_W'(WIN)) ? UPDATE : IDLE;
            end
            UPDATE: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pacing counter, timeout timer, accumulator and status flags.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            period_q <= PER_W'(SAMPLE_DIV - 1);
            wait_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            period_q <= period_d;
            wait_q   <= wait_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            fault_q  <= fault_d;
        end
    end

    // Result publication: average, min/max tracking and hysteretic alarms.
    always_comb begin
        valid_d   = 1'b0;
        avg_raw_d = avg_raw_q;
        min_d     = min_q;
        max_d     = max_q;
        ok_d      = ok_q;
        ah_d      = ah_q;
        al_d      = al_q;

        if (upd) begin
            valid_d   = 1'b1;
            avg_raw_d = avg_now;
            if (!ok_q || clr_minmax) begin
                min_d = c_now;
                max_d = c_now;
                ok_d  = 1'b1;
            end else begin
                if (c_now < min_q) min_d = c_now;
                if (c_now > max_q) max_d = c_now;
            end
            if (avg_x >= hi_set)      ah_d = 1'b1;
            else if (avg_x < hi_clr)  ah_d = 1'b0;
            if (avg_x <= lo_set)      al_d = 1'b1;
            else if (avg_x > lo_clr)  al_d = 1'b0;
        end else if (clr_minmax) begin
            ok_d = 1'b0;
        end
    end

    // Result registers.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            valid_q   <= 1'b0;
            avg_raw_q <= '0;
            min_q     <= '0;
            max_q     <= '0;
            ok_q      <= 1'b0;
            ah_q      <= 1'b0;
            al_q      <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            avg_raw_q <= avg_raw_d;
            min_q     <= min_d;
            max_q     <= max_d;
            ok_q      <= ok_d;
            ah_q      <= ah_d;
            al_q      <= al_d;
        end
    end

    temp_fmt #(
        .DATA_W (DATA_W)
    ) u_fmt (
        .clk_i    (clk_100MHz),
        .reset_i  (reset),
        .load_i   (upd),
        .raw_i    (avg_now),
        .c_comb_o (c_now),
        .avg_c_o  (avg_c),
        .avg_f_o  (avg_f)
    );

    assign sample_req   = req_q;
    assign sensor_fault = fault_q;
    assign avg_valid    = valid_q;
    assign avg_raw      = avg_raw_q;
    assign min_c        = min_q;
    assign max_c        = max_q;
    assign minmax_ok    = ok_q;
    assign alarm_high   = ah_q;
    assign alarm_low    = al_q;

endmodule

// File: tb/tb_temp_monitor.sv
// Directed-plus-random bench for temp_monitor with an arithmetic reference
// model of the window average, conversions, min/max and alarms.
module tb_temp_monitor;

    localparam int DIV  = 20;
    localparam int TOUT = 10;
    localparam int NWIN = 4;
    localparam int HYS  = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_req;
    logic               raw_valid = 1'b0;
    logic signed [12:0] raw_data = '0;
    logic signed [12:0] thr_high = '0;
    logic signed [12:0] thr_low = '0;
    logic               clr_minmax = 1'b0;
    logic               avg_valid;
    logic signed [12:0] avg_raw;
    logic signed [7:0]  avg_c, avg_f, min_c, max_c;
    logic               minmax_ok, alarm_high, alarm_low, sensor_fault;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    // Reference model state.
    int win[$];
    int th_hi, th_lo;
    int m_min, m_max;
    bit m_ok, m_ah, m_al;

    temp_monitor #(
        .DATA_W(13), .AVG_LOG2(2), .SAMPLE_DIV(DIV), .TIMEOUT_CYC(TOUT), .HYST(HYS)
    ) dut (
        .clk_100MHz(clk), .reset(reset), .sample_req(sample_req),
        .raw_valid(raw_valid), .raw_data(raw_data),
        .thr_high(thr_high), .thr_low(thr_low), .clr_minmax(clr_minmax),
        .avg_valid(avg_valid), .avg_raw(avg_raw), .avg_c(avg_c), .avg_f(avg_f),
        .min_c(min_c), .max_c(max_c), .minmax_ok(minmax_ok),
        .alarm_high(alarm_high), .alarm_low(alarm_low), .sensor_fault(sensor_fault)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    function automatic int clamp8(input int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    task automatic set_thr(input int hi, input int lo);
        th_hi = hi;
        th_lo = lo;
        thr_high = 13'(hi);
        thr_low = 13'(lo);
    endtask

    // Hold reset, check the cleared outputs, release and time the first request.
    task automatic reset_and_first_req();
        int early = 0;
        reset = 1'b1;
        raw_valid = 1'b0;
        clr_minmax = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_avg_valid", avg_valid, 0);
        check("rst_avg_raw", avg_raw, 0);
        check("rst_avg_c", avg_c, 0);
        check("rst_avg_f", avg_f, 0);
        check("rst_min_c", min_c, 0);
        check("rst_max_c", max_c, 0);
        check("rst_minmax_ok", minmax_ok, 0);
        check("rst_alarm_high", alarm_high, 0);
        check("rst_alarm_low", alarm_low, 0);
        check("rst_fault", sensor_fault, 0);
        check("rst_sample_req", sample_req, 0);
        win.delete();
        m_ok = 0; m_ah = 0; m_al = 0; m_min = 0; m_max = 0;
        reset = 1'b0;
        for (int k = 1; k <= DIV; k++) begin
            @(negedge clk);
            if (k < DIV && sample_req === 1'b1) early++;
            if (avg_valid === 1'b1) early++;
        end
        check("req_early_or_valid", early, 0);
        check("req_first", sample_req, 1);
        check("req_first_cycle", cyc, DIV);
    endtask

    // Wait (bounded) for the next request and check it falls on the period grid.
    task automatic wait_req();
        bit seen = 0;
        for (int n = 0; n < 3 * DIV; n++) begin
            @(negedge clk);
            if (sample_req === 1'b1) begin
                seen = 1;
                break;
            end
        end
        check("req_seen", int'(seen), 1);
        check("req_phase", cyc % DIV, 0);
    endtask

    // Answer the pending request; if it completes a window, check the results.
    task automatic give_sample(input int v, input bit clr_upd);
        int sum, e_avg, e_c, e_f;
        repeat ($urandom_range(0, 5)) @(negedge clk);
        raw_valid = 1'b1;
        raw_data = 13'(v);
        @(negedge clk);
        raw_valid = 1'b0;
        win.push_back(v);
        check("fault_cleared", sensor_fault, 0);
        check("valid_at_t", avg_valid, 0);
        if (win.size() == NWIN) begin
            sum = 0;
            foreach (win[i]) sum += win[i];
            win.delete();
            e_avg = floor_div(sum, NWIN);
            e_c = clamp8(floor_div(e_avg, 16));
            e_f = clamp8((e_c * 9) / 5 + 32);
            if (!m_ok || clr_upd) begin
                m_min = e_c; m_max = e_c; m_ok = 1;
            end else begin
                if (e_c < m_min) m_min = e_c;
                if (e_c > m_max) m_max = e_c;
            end
            if (e_avg >= th_hi) m_ah = 1;
            else if (e_avg < th_hi - HYS) m_ah = 0;
            if (e_avg <= th_lo) m_al = 1;
            else if (e_avg > th_lo + HYS) m_al = 0;
            clr_minmax = clr_upd;
            @(negedge clk);
            check("valid_at_t1", avg_valid, 0);
            @(negedge clk);
            clr_minmax = 1'b0;
            check("valid_at_t2", avg_valid, 1);
            check("avg_raw", avg_raw, e_avg);
            check("avg_c", avg_c, e_c);
            check("avg_f", avg_f, e_f);
            check("min_c", min_c, m_min);
            check("max_c", max_c, m_max);
            check("minmax_ok", minmax_ok, 1);
            check("alarm_high", alarm_high, int'(m_ah));
            check("alarm_low", alarm_low, int'(m_al));
            @(negedge clk);
            check("valid_pulse_end", avg_valid, 0);
        end
    endtask

    task automatic run_window(input int a, input int b, input int c, input int d,
                              input bit req_seen, input bit clr);
        int vals[4];
        vals = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            if (!(i == 0 && req_seen)) wait_req();
            give_sample(vals[i], clr && (i == 3));
        end
    endtask

    initial begin
        int r, fault_wait;
        int bvals[4];
        set_thr(4095, -4096);

        reset_and_first_req();
        run_window(400, 400, 400, 400, 1'b1, 1'b0);

        // A strobe outside WAIT must not enter the window.
        raw_valid = 1'b1;
        raw_data = 13'h0fff;
        @(negedge clk);
        raw_valid = 1'b0;

        bvals = '{385, 386, 387, 388};
        r = $urandom_range(0, 3);
        run_window(bvals[r], bvals[(r + 1) % 4], bvals[(r + 2) % 4], bvals[(r + 3) % 4],
                   1'b0, 1'b0);
        run_window(-640, -640, -640, -640, 1'b0, 1'b0);

        for (int w = 0; w < 3; w++) begin
            int rv[4];
            for (int i = 0; i < 4; i++) rv[i] = $urandom_range(0, 8191) - 4096;
            run_window(rv[0], rv[1], rv[2], rv[3], 1'b0, 1'b0);
        end

        set_thr(416, -4096);
        run_window(416, 416, 416, 416, 1'b0, 1'b0);
        run_window(408, 408, 408, 408, 1'b0, 1'b0);
        run_window(398, 398, 398, 398, 1'b0, 1'b0);

        set_thr(4095, 16);
        run_window(16, 16, 16, 16, 1'b0, 1'b0);
        run_window(30, 30, 30, 30, 1'b0, 1'b0);
        run_window(33, 33, 33, 33, 1'b0, 1'b0);

        // Partial window, then a silent sensor.
        wait_req();
        give_sample(100, 1'b0);
        wait_req();
        give_sample(100, 1'b0);
        wait_req();
        fault_wait = 0;
        while (sensor_fault !== 1'b1 && fault_wait < TOUT + 5) begin
            @(negedge clk);
            if (avg_valid === 1'b1) fault_wait = 100;
            fault_wait++;
        end
        check("fault_set", sensor_fault, 1);
        check("fault_in_time", int'(fault_wait <= TOUT + 1), 1);
        win.delete();
        run_window(-300, -300, -300, -300, 1'b0, 1'b0);

        // Clear alone: flag drops, extremes keep their stale values.
        clr_minmax = 1'b1;
        @(negedge clk);
        clr_minmax = 1'b0;
        m_ok = 0;
        check("clr_ok", minmax_ok, 0);
        check("clr_min_stale", min_c, m_min);
        check("clr_max_stale", max_c, m_max);
        run_window(200, 200, 200, 200, 1'b0, 1'b0);

        run_window(2032, 2032, 2032, 2032, 1'b0, 1'b1);
        run_window(-4096, -4096, -4096, -4096, 1'b0, 1'b0);

        // Reset in the middle of a window.
        for (int i = 0; i < 3; i++) begin
            wait_req();
            give_sample(1000, 1'b0);
        end
        reset_and_first_req();
        run_window(-17, -18, -19, -20, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
